// File: rtl/ps2_dev_fifo_tx_if.sv
// Push-side bus between the HPS command decoder and ps2_dev_fifo_tx.
interface ps2_dev_fifo_tx_if #(
  parameter int CHANNELS = 2
);
  logic                wr_en;
  logic [2:0]          wr_ch;
  logic [7:0]          wr_data;
  logic [CHANNELS-1:0] wr_full;
  logic [CHANNELS-1:0] ovf;
  logic [CHANNELS-1:0] ovf_clr;

  modport master (output wr_en, wr_ch, wr_data, ovf_clr, input wr_full, ovf);
  modport slave  (input wr_en, wr_ch, wr_data, ovf_clr, output wr_full, ovf);
endinterface

// File: rtl/ps2_dev_fifo_tx.sv
// Multi-channel PS/2 device-to-host transmitter: per-channel byte FIFO feeding an 11-bit
// frame serialiser on a shared bit clock. Define PS2_INHIBIT_EN for host-inhibit abort/retransmit.
module ps2_dev_fifo_tx #(
  parameter int CHANNELS  = 2,
  parameter int FIFO_BITS = 3,
  parameter int PS2DIV    = 1000
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  ps2_dev_fifo_tx_if.slave    bus,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] ps2_clk,
  output logic [CHANNELS-1:0] ps2_data
`ifdef PS2_INHIBIT_EN
  ,
  input  logic [CHANNELS-1:0] ps2_clk_in
`endif
);
  localparam int PW    = FIFO_BITS + 1;
  localparam int DEPTH = 1 << FIFO_BITS;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_B7   = 4'd8;
  localparam logic [3:0] ST_PAR  = 4'd9;
  localparam logic [3:0] ST_STOP = 4'd10;
  localparam logic [3:0] ST_END  = 4'd11;

  logic [31:0]         div_cnt;
  logic                clk_ps2;
  logic                clk_ps2_q;
  logic                tick;
  logic [CHANNELS-1:0] inhibit;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      clk_ps2   <= 1'b0;
      clk_ps2_q <= 1'b0;
    end else begin
      clk_ps2_q <= clk_ps2;
      if (div_cnt == 32'(PS2DIV)) begin
        div_cnt <= '0;
        clk_ps2 <= ~clk_ps2;
      end else begin
        div_cnt <= div_cnt + 32'd1;
      end
    end
  end

  // One-cycle strobe following each rising edge of the shared bit clock
  assign tick = clk_ps2 & ~clk_ps2_q;

`ifdef PS2_INHIBIT_EN
  logic [CHANNELS-1:0] clk_in_s1;
  logic [CHANNELS-1:0] clk_in_s2;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_in_s1 <= '1;
      clk_in_s2 <= '1;
    end else begin
      clk_in_s1 <= ps2_clk_in;
      clk_in_s2 <= clk_in_s1;
    end
  end

  assign inhibit = ~clk_in_s2;
`else
  assign inhibit = '0;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    shreg;
    logic [3:0]    state;
    logic          parity;
    logic          data_r;
    logic          ovf_r;
    logic          sel;
    logic          full;
    logic          empty;
    logic          push;
    logic          drop;
    logic          start;
    logic          abort;
    logic          pop;

    assign sel   = bus.wr_en && (bus.wr_ch == 3'(c));
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = sel && !full;
    assign drop  = sel && full;
    assign start = tick && (state == ST_IDLE) && !empty && !inhibit[c];
    assign abort = tick && inhibit[c] && (state != ST_IDLE) && (state <= ST_STOP);
    // Head byte leaves the FIFO only once its stop bit goes out, so an abort can resend it
    assign pop   = tick && (state == ST_STOP) && !inhibit[c];

    always_ff @(posedge clk_sys) begin
      if (push) mem[wr_ptr[PW-2:0]] <= bus.wr_data;
      if (start) begin
        shreg  <= mem[rd_ptr[PW-2:0]];
        parity <= 1'b1;
      end else if (tick && (state != ST_IDLE) && (state <= ST_B7)) begin
        shreg  <= {1'b0, shreg[7:1]};
        parity <= parity ^ shreg[0];
      end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf_r  <= 1'b0;
        state  <= ST_IDLE;
        data_r <= 1'b1;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (drop)                ovf_r <= 1'b1;
        else if (bus.ovf_clr[c]) ovf_r <= 1'b0;

        if (abort) begin
          data_r <= 1'b1;
          state  <= ST_IDLE;
        end else if (start) begin
          data_r <= 1'b0;
          state  <= 4'd1;
        end else if (tick && (state != ST_IDLE)) begin
          if (state <= ST_B7)        data_r <= shreg[0];
          else if (state == ST_PAR)  data_r <= parity;
          else                       data_r <= 1'b1;
          state <= (state >= ST_END) ? ST_IDLE : state + 4'd1;
        end
      end
    end

    assign bus.wr_full[c] = full;
    assign bus.ovf[c]     = ovf_r;
    assign busy[c]        = (state != ST_IDLE);
    assign ps2_data[c]    = data_r;
    assign ps2_clk[c]     = clk_ps2 | (state == ST_IDLE);
  end

endmodule

// File: tb/tb_ps2_dev_fifo_tx.sv
// Bench for ps2_dev_fifo_tx: directed frame table, overflow/reset/inhibit sequences, random pushes.
module tb_ps2_dev_fifo_tx;
  localparam int CH       = 2;
  localparam int FB       = 3;
  localparam int DIV      = 4;
  localparam int TICK     = 2 * (DIV + 1);
  localparam int BUSY_CYC = 11 * TICK;
  localparam int GAP_CYC  = 12 * TICK;
  localparam int NV       = 7;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b1;
  logic [CH-1:0] busy;
  logic [CH-1:0] ps2_clk;
  logic [CH-1:0] ps2_data;
`ifdef PS2_INHIBIT_EN
  logic [CH-1:0] ps2_clk_in = '1;
`endif

  always #5 clk_sys = ~clk_sys;

  ps2_dev_fifo_tx_if #(.CHANNELS(CH)) bus ();

  ps2_dev_fifo_tx #(.CHANNELS(CH), .FIFO_BITS(FB), .PS2DIV(DIV)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .bus      (bus),
    .busy     (busy),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
`ifdef PS2_INHIBIT_EN
    ,
    .ps2_clk_in (ps2_clk_in)
`endif
  );

  // Host-side receiver: samples data on each falling PS/2 clock, as a real host does
  int            cyc = 0;
  logic [CH-1:0] clk_prev = '1;
  logic [CH-1:0] busy_prev = '0;
  logic [CH-1:0] clk_viol = '0;
  logic [10:0]   rx_sh [CH];
  int            nbits [CH];
  logic [10:0]   rx_frame [CH][128];
  int            rx_cnt [CH];
  int            run [CH];
  int            busy_len [CH][128];
  int            fall_n [CH];
  int            rise_t [CH][128];
  int            rise_n [CH];

  always @(negedge clk_sys) begin
    cyc       <= cyc + 1;
    clk_prev  <= ps2_clk;
    busy_prev <= busy;
    for (int c = 0; c < CH; c++) begin
      if (!busy[c] && !ps2_clk[c]) clk_viol[c] <= 1'b1;
      if (busy[c] && !busy_prev[c]) begin
        rise_t[c][rise_n[c] % 128] <= cyc;
        rise_n[c] <= rise_n[c] + 1;
      end
      run[c] <= busy[c] ? run[c] + 1 : 0;
      if (!busy[c] && busy_prev[c]) begin
        busy_len[c][fall_n[c] % 128] <= run[c];
        fall_n[c] <= fall_n[c] + 1;
      end
      if (!reset_n || !busy[c]) begin
        nbits[c] <= 0;
      end else if (clk_prev[c] && !ps2_clk[c]) begin
        if (nbits[c] == 10) begin
          rx_frame[c][rx_cnt[c] % 128] <= {ps2_data[c], rx_sh[c][10:1]};
          rx_cnt[c] <= rx_cnt[c] + 1;
          nbits[c]  <= 0;
        end else begin
          rx_sh[c] <= {ps2_data[c], rx_sh[c][10:1]};
          nbits[c] <= nbits[c] + 1;
        end
      end
    end
  end

  int          errors = 0;
  int          checks = 0;
  logic [10:0] exp_frame [CH][128];
  int          exp_n [CH];
  int          chk_n [CH];

  typedef struct {
    int          ch;
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;
  vec_t vt [NV];

  // Reference frame: start 0, data LSB first, odd parity, stop 1 (bit 0 goes out first)
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] b);
    @(posedge clk_sys); #1;
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 3'(ch);
    bus.wr_data = b;
    @(posedge clk_sys); #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic exp_push(input int ch, input logic [10:0] f);
    exp_frame[ch][exp_n[ch]] = f;
    exp_n[ch]++;
  endtask

  task automatic wait_rx(input int ch, input int budget);
    int t = 0;
    while (rx_cnt[ch] < exp_n[ch] && t < budget) begin
      @(posedge clk_sys);
      t++;
    end
    #1;
    if (rx_cnt[ch] < exp_n[ch]) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout ch%0d: got %0d frames want %0d", ch, rx_cnt[ch], exp_n[ch]);
    end
    for (int i = chk_n[ch]; i < exp_n[ch] && i < rx_cnt[ch]; i++)
      check($sformatf("frame_ch%0d_%0d", ch, i), 32'(rx_frame[ch][i]), 32'(exp_frame[ch][i]));
    chk_n[ch] = exp_n[ch];
  endtask

  task automatic wait_fall(input int ch, input int prev, input int budget);
    int t = 0;
    while (fall_n[ch] <= prev && t < budget) begin
      @(posedge clk_sys);
      t++;
    end
    #1;
    if (fall_n[ch] <= prev) begin
      checks++;
      errors++;
      $display("FAIL busy_fall_timeout ch%0d: got %0d falls want >%0d", ch, fall_n[ch], prev);
    end
  endtask

  initial begin
    int         ch;
    int         f0;
    int         t;
    int         k;
    logic [7:0] b;

    vt[0] = '{0, 8'hA5, {1'b1, 1'b1, 8'hA5, 1'b0}};
    vt[1] = '{1, 8'h00, {1'b1, 1'b1, 8'h00, 1'b0}};
    vt[2] = '{0, 8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0}};
    vt[3] = '{1, 8'h01, {1'b1, 1'b0, 8'h01, 1'b0}};
    vt[4] = '{0, 8'h80, {1'b1, 1'b0, 8'h80, 1'b0}};
    vt[5] = '{1, 8'h7F, {1'b1, 1'b0, 8'h7F, 1'b0}};
    vt[6] = '{0, 8'h3C, {1'b1, 1'b1, 8'h3C, 1'b0}};

    bus.wr_en   = 1'b0;
    bus.wr_ch   = 3'd0;
    bus.wr_data = 8'h00;
    bus.ovf_clr = '0;

    #3 reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_ps2_data", 32'(ps2_data), 32'h3);
    check("reset_ps2_clk", 32'(ps2_clk), 32'h3);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_ovf", 32'(bus.ovf), 32'h0);
    check("reset_wr_full", 32'(bus.wr_full), 32'h0);
    reset_n = 1'b1;

    // Directed frames, one at a time
    for (int i = 0; i < NV; i++) begin
      ch = vt[i].ch;
      f0 = fall_n[ch];
      push(ch, vt[i].data);
      exp_push(ch, vt[i].frame);
      wait_rx(ch, 3 * GAP_CYC);
      wait_fall(ch, f0, 3 * TICK);
      if (fall_n[ch] > 0)
        check($sformatf("busy_len_vec%0d", i), 32'(busy_len[ch][(fall_n[ch] - 1) % 128]), 32'(BUSY_CYC));
    end

    // Fill ch1 with 9 bytes; the ninth is dropped
    for (int i = 1; i <= 9; i++) begin
      push(1, 8'(i));
      if (i <= 8) exp_push(1, frame_of(8'(i)));
      if (i == 7) check("full_after_7", 32'(bus.wr_full[1]), 32'd0);
      if (i == 8) begin
        check("full_after_8", 32'(bus.wr_full[1]), 32'd1);
        check("ovf_before_drop", 32'(bus.ovf[1]), 32'd0);
      end
    end
    check("ovf_after_drop", 32'(bus.ovf[1]), 32'd1);
    check("ovf_ch0_untouched", 32'(bus.ovf[0]), 32'd0);
    wait_rx(1, 10 * GAP_CYC);
    if (rise_n[1] >= 2)
      check("back_to_back_gap", 32'(rise_t[1][(rise_n[1] - 1) % 128] - rise_t[1][(rise_n[1] - 2) % 128]),
            32'(GAP_CYC));
    check("ovf_sticky", 32'(bus.ovf[1]), 32'd1);
    check("full_after_drain", 32'(bus.wr_full[1]), 32'd0);

    // Overflow push and clear in the same cycle: set wins, then a lone clear takes effect
    for (int i = 0; i < 8; i++) begin
      push(1, 8'(8'h41 + i));
      exp_push(1, frame_of(8'(8'h41 + i)));
    end
    check("refull", 32'(bus.wr_full[1]), 32'd1);
    @(posedge clk_sys); #1;
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 3'd1;
    bus.wr_data = 8'h49;
    bus.ovf_clr = 2'b10;
    @(posedge clk_sys); #1;
    bus.wr_en = 1'b0;
    check("ovf_set_beats_clr", 32'(bus.ovf[1]), 32'd1);
    @(posedge clk_sys); #1;
    bus.ovf_clr = '0;
    check("ovf_clr_alone", 32'(bus.ovf[1]), 32'd0);
    wait_rx(1, 10 * GAP_CYC);

    // Concurrent frames on both channels, launched right after a frame boundary
    f0 = fall_n[0];
    push(0, 8'h5C);
    exp_push(0, frame_of(8'h5C));
    wait_fall(0, f0, 2 * GAP_CYC);
    push(0, 8'h12);
    exp_push(0, {1'b1, 1'b1, 8'h12, 1'b0});
    push(1, 8'h34);
    exp_push(1, {1'b1, 1'b0, 8'h34, 1'b0});
    wait_rx(0, 3 * GAP_CYC);
    wait_rx(1, 3 * GAP_CYC);
    if (rise_n[0] > 0 && rise_n[1] > 0)
      check("concurrent_start", 32'(rise_t[0][(rise_n[0] - 1) % 128]), 32'(rise_t[1][(rise_n[1] - 1) % 128]));

    // Out-of-range channel is ignored
    repeat (GAP_CYC) @(posedge clk_sys);
    push(5, 8'hEE);
    repeat (3 * TICK) @(posedge clk_sys);
    #1;
    check("ch5_busy", 32'(busy), 32'h0);
    check("ch5_full", 32'(bus.wr_full), 32'h0);
    check("ch5_ovf", 32'(bus.ovf), 32'h0);

    // Reset in the middle of a frame with more bytes queued
    push(0, 8'h99);
    push(0, 8'h11);
    push(0, 8'h22);
    t = 0;
    while (nbits[0] != 5 && t < 3 * GAP_CYC) begin
      @(posedge clk_sys);
      t++;
    end
    check("reached_state5", 32'(nbits[0]), 32'd5);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_ps2_data", 32'(ps2_data), 32'h3);
    check("midreset_ps2_clk", 32'(ps2_clk), 32'h3);
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_wr_full", 32'(bus.wr_full), 32'h0);
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    push(0, 8'hC3);
    exp_push(0, frame_of(8'hC3));
    wait_rx(0, 3 * GAP_CYC);

`ifdef PS2_INHIBIT_EN
    // Host pulls its clock low mid-frame: abort, hold off, then resend the same byte
    push(0, 8'h5A);
    exp_push(0, {1'b1, 1'b1, 8'h5A, 1'b0});
    push(0, 8'h66);
    exp_push(0, frame_of(8'h66));
    k = rx_cnt[0];
    t = 0;
    while (nbits[0] != 4 && t < 3 * GAP_CYC) begin
      @(posedge clk_sys);
      t++;
    end
    check("reached_state4", 32'(nbits[0]), 32'd4);
    #1 ps2_clk_in[0] = 1'b0;
    t = 0;
    while (busy[0] && t < 3 * TICK) begin
      @(posedge clk_sys);
      t++;
    end
    #1;
    check("inhibit_busy_drop", 32'(busy[0]), 32'd0);
    check("inhibit_data_high", 32'(ps2_data[0]), 32'd1);
    repeat (5 * TICK) @(posedge clk_sys);
    #1;
    check("inhibit_no_start", 32'(busy[0]), 32'd0);
    check("inhibit_no_frame", 32'(rx_cnt[0]), 32'(k));
    ps2_clk_in[0] = 1'b1;
    wait_rx(0, 4 * GAP_CYC);
`endif

    // Random pushes against the queue model, kept below full so no drops are expected
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) ch = int'($urandom_range(2, 7));
      else                           ch = int'($urandom_range(0, 1));
      b = 8'($urandom);
      if (ch >= CH) begin
        push(ch, b);
      end else if (exp_n[ch] - rx_cnt[ch] < 6) begin
        push(ch, b);
        exp_push(ch, frame_of(b));
      end
      repeat ($urandom_range(0, 30)) @(posedge clk_sys);
    end
    wait_rx(0, 8 * GAP_CYC);
    wait_rx(1, 8 * GAP_CYC);
    check("random_ovf", 32'(bus.ovf), 32'h0);
    check("random_full", 32'(bus.wr_full), 32'h0);

    repeat (3 * GAP_CYC) @(posedge clk_sys);
    #1;
    for (int c = 0; c < CH; c++) begin
      check($sformatf("frame_count_ch%0d", c), 32'(rx_cnt[c]), 32'(exp_n[c]));
      check($sformatf("clk_idle_high_ch%0d", c), 32'(clk_viol[c]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_dev_fifo_tx.md
# ps2_dev_fifo_tx

- Multi-channel PS/2 device-side transmitter with a FIFO per channel and a shared, programmable PS/2 bit clock.
- Sits between the HPS command decoder and the core's PS/2 keyboard/mouse inputs; replaces per-device hand-coded transmitters.
- The decoder pushes bytes tagged with a channel number. Each channel serialises its bytes as standard 11-bit PS/2 device-to-host frames.
- Adds full/overflow reporting, and optional host-inhibit abort and retransmit.

## Interface
- CHANNELS, 2, number of independent PS/2 channels (1..8).
- FIFO_BITS, 3, log2 of FIFO depth per channel; depth = 2^FIFO_BITS.
- PS2DIV, 1000, bit-clock divider; clk_ps2 period = 2*(PS2DIV+1) clk_sys cycles.
- clk_sys  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  push strobe, one byte per cycle.
- wr_ch  in  3  target channel; values >= CHANNELS are ignored.
- wr_data  in  8  byte to push.
- wr_full  out  CHANNELS  per-channel FIFO full; combinational from pointers.
- ovf  out  CHANNELS  sticky flag: a push was dropped.
- ovf_clr  in  CHANNELS  per-channel clear of ovf.
- busy  out  CHANNELS  frame in progress (state != 0).
- ps2_clk  out  CHANNELS  PS/2 clock: clk_ps2 OR idle.
- ps2_data  out  CHANNELS  PS/2 data line.
- ps2_clk_in  in  CHANNELS  host clock sense; present only with PS2_INHIBIT_EN.

## Operation
Divider
- 32-bit counter runs 0..PS2DIV; when it reaches PS2DIV, clk_ps2 toggles and the counter clears.
- A tick is the clk_sys cycle after a rising edge of clk_ps2 is detected.
- All channels share the divider and tick.

FIFO
- Read and write pointers are FIFO_BITS+1 wide.
- Full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal.
- A push to a full channel is dropped and sets ovf.
- Set beats ovf_clr in the same cycle.

Transmit FSM, per channel; state advances only on tick.
- State 0, idle: if the FIFO is non-empty (and the host is not inhibiting), latch the head byte, set parity=1, drive data=0 (start bit), go to state 1.
- States 1..8: drive bit[state-1], LSB first. Parity toggles for each 1 bit, so the parity bit is odd parity.
- State 9: drive parity.
- State 10: drive 1 (stop bit) and advance the read pointer.
- State 11: go to state 0.
- The read pointer advances only at state 10. The head byte stays in the FIFO until its frame completes.

Width rules
- Pointer arithmetic wraps modulo 2^(FIFO_BITS+1).
- The FSM state is 4 bits.

## Timing
Reset values
- ps2_data = all 1; ps2_clk = all 1; busy = 0; ovf = 0; wr_full = 0.
- Pointers, FSM state, divider and clk_sys-domain clk_ps2 = 0.

Push and full
- A push is visible to the FSM at the next tick.
- wr_full asserts in the cycle after the push that fills the FIFO.

Frame timing
- One frame spans 12 ticks, start to return-to-idle.
- Back-to-back bytes start 12 ticks apart = 24*(PS2DIV+1) clk_sys cycles.

Other boundaries
- A push and the state-10 pop on the same channel in the same cycle both take effect; the occupancy count is unchanged.
- Reset mid-frame: lines return high immediately and FIFO contents are discarded.

## Configuration
PS2_INHIBIT_EN
- Defined:
  - ps2_clk_in is synchronised through 2 flops.
  - Low at a tick in states 1..10: data=1, state=0, read pointer unchanged; the same byte is retransmitted once the host releases the clock.
  - Low in state 0: no frame starts.
- Undefined:
  - The port is absent and the FSM never aborts.

## Test plan
- PS2DIV=4; push 0xA5 to ch0 -> ps2_data across ticks 0,1,0,1,0,0,1,0,1,1,1, then idle high; busy high for 11 ticks; ps2_clk toggles only while busy.
- Push 9 bytes 0x01..0x09 to ch1 with no drain -> wr_full[1]=1 after the 8th; ovf[1]=1; output order 0x01..0x08; 0x09 is never sent.
- Same-cycle ovf_clr[1] and an overflow push -> ovf[1] stays 1. Next-cycle clear alone -> 0.
- Pushes interleaved to ch0 (0x12) and ch1 (0x34) -> both frames run concurrently on the same ticks with independent data; wr_ch=5 with CHANNELS=2 changes no state.
- Assert reset_n low at state 5 -> all outputs go to reset values within 0 cycles. After release, a new push transmits from the start bit.
- With PS2_INHIBIT_EN, pull ps2_clk_in low during state 4 of 0x5A -> data goes high and busy drops. After release, the full 0x5A frame is resent and the FIFO pops exactly once.
